// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: input synchronizers, frame FSM, parity/stop check and show-ahead receive FIFO.
// Optional bit-edge timeout is enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx_fifo #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PARITY_ODD  = 1,
  parameter int unsigned TIMEOUT_CYC = 800
) (
  input  logic                             ref_clk,
  input  logic                             reset,
  input  logic                             clk_in,
  input  logic                             serial_in,
  input  logic                             rx_done,
  output logic [DATA_W-1:0]                data_out,
  output logic                             receive,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  count,
  output logic                             overflow,
  output logic                             parity_err,
  output logic                             frame_err
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ps2_rx_fifo: FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("ps2_rx_fifo: SYNC_STAGES must be >= 2");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_tmo
    $error("ps2_rx_fifo: TIMEOUT_CYC must be >= 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } state_e;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  state_e                 state_q, state_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic                   par_q, par_d;
  logic [DATA_W-1:0]      mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]      mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   receive_q, receive_d;
  logic [DATA_W-1:0]      data_out_q, data_out_d;
  logic                   overflow_q, overflow_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d;
`ifdef PS2_RX_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0]       tmo_q, tmo_d;
`endif

  logic fall_c;
  logic sdat_c;
  logic push_req_c;
  logic pop_c;
  logic full_c;
  logic push_c;

  assign fall_c = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign sdat_c = dat_sync_q[SYNC_STAGES-1];

  // Synchronizers, edge detect and frame FSM
  always_comb begin
    clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], clk_in};
    dat_sync_d   = {dat_sync_q[SYNC_STAGES-2:0], serial_in};
    clk_prev_d   = clk_sync_q[SYNC_STAGES-1];
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    push_req_c   = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fall_c && !sdat_c) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (fall_c) begin
          shift_d[bit_cnt_q] = sdat_c;
          if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
            state_d = ST_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (fall_c) begin
          par_d   = sdat_c;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall_c) begin
          if (sdat_c) begin
            if (((^shift_q) ^ par_q) == 1'(PARITY_ODD)) begin
              push_req_c = 1'b1;
            end else begin
              parity_err_d = 1'b1;
            end
            state_d = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (sdat_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef PS2_RX_TIMEOUT_EN
    // Stall watchdog: restarts on every falling edge while a frame is open
    tmo_d = '0;
    if (state_q == ST_DATA || state_q == ST_PARITY || state_q == ST_STOP) begin
      if (fall_c) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
        frame_err_d = 1'b1;
        push_req_c  = 1'b0;
        state_d     = ST_IDLE;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
`endif
  end

  // Show-ahead FIFO; a pop frees a slot for a same-cycle push even when full
  always_comb begin
    pop_c      = rx_done & receive_q;
    full_c     = (count_q == CNT_W'(FIFO_DEPTH));
    push_c     = push_req_c & (~full_c | pop_c);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push_req_c & full_c & ~pop_c);

    if (push_c) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    receive_d  = (count_d != '0);
    data_out_d = receive_d ? mem_d[rd_ptr_d] : '0;
  end

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      clk_sync_q   <= '1;
      dat_sync_q   <= '1;
      clk_prev_q   <= 1'b1;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      receive_q    <= 1'b0;
      data_out_q   <= '0;
      overflow_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
`ifdef PS2_RX_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      clk_sync_q   <= clk_sync_d;
      dat_sync_q   <= dat_sync_d;
      clk_prev_q   <= clk_prev_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      receive_q    <= receive_d;
      data_out_q   <= data_out_d;
      overflow_q   <= overflow_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
`ifdef PS2_RX_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign data_out   = data_out_q;
  assign receive    = receive_q;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: expected words are queued as frames are sent, a monitor pops and compares.
module tb_ps2_rx_fifo;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned SYNC   = 2;
  localparam int unsigned HALF   = 8;

  logic        ref_clk = 1'b0;
  logic        reset;
  logic        clk_in;
  logic        serial_in;
  logic        rx_done;
  logic [7:0]  data_out;
  logic        receive;
  logic [2:0]  count;
  logic        overflow;
  logic        parity_err;
  logic        frame_err;

  logic        mon_pop = 1'b0;
  logic        tb_pop  = 1'b0;
  logic        pop_en  = 1'b0;
  assign rx_done = mon_pop | tb_pop;

  int          total = 0;
  int          bad   = 0;
  int          perr_seen = 0;
  int          ferr_seen = 0;
  logic        perr_prev = 1'b0;
  logic        ferr_prev = 1'b0;
  logic [7:0]  exp_q[$];

  ps2_rx_fifo #(
    .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC),
    .PARITY_ODD(1), .TIMEOUT_CYC(800)
  ) dut (
    .ref_clk(ref_clk), .reset(reset), .clk_in(clk_in), .serial_in(serial_in),
    .rx_done(rx_done), .data_out(data_out), .receive(receive), .count(count),
    .overflow(overflow), .parity_err(parity_err), .frame_err(frame_err)
  );

  always #5 ref_clk = ~ref_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: drains the FIFO whenever allowed and scores each head word
  always @(negedge ref_clk) begin
    logic [7:0] w;
    mon_pop = 1'b0;
    if (!reset && pop_en && receive) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got 0x%0h expected none", data_out);
      end else begin
        w = exp_q.pop_front();
        check("pop_data", 32'(data_out), 32'(w));
      end
      mon_pop = 1'b1;
    end
    if (parity_err) begin
      perr_seen++;
      if (perr_prev) check("parity_err_width", 32'd2, 32'd1);
    end
    if (frame_err) begin
      ferr_seen++;
      if (ferr_prev) check("frame_err_width", 32'd2, 32'd1);
    end
    perr_prev = parity_err;
    ferr_prev = frame_err;
  end

  function automatic logic odd_par(input logic [7:0] d);
    return ~(^d);
  endfunction

  task automatic ps2_bit(input logic b, input bit pop_on_fall);
    serial_in = b;
    repeat (HALF) @(negedge ref_clk);
    clk_in = 1'b0;
    if (pop_on_fall) begin
      logic [7:0] w;
      // Land rx_done on the same cycle the stop-bit fall pushes the new word
      repeat (SYNC) @(negedge ref_clk);
      w = exp_q.pop_front();
      check("full_head", 32'(data_out), 32'(w));
      tb_pop = 1'b1;
      @(negedge ref_clk);
      tb_pop = 1'b0;
      repeat (HALF - SYNC - 1) @(negedge ref_clk);
    end else begin
      repeat (HALF) @(negedge ref_clk);
    end
    clk_in = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input bit pop_on_stop);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i], 1'b0);
    ps2_bit(par, 1'b0);
    ps2_bit(stop, pop_on_stop);
    repeat (HALF) @(negedge ref_clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge ref_clk);
    reset = 1'b0;
    @(negedge ref_clk);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || receive) && n < 300) begin
      @(negedge ref_clk);
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_count0"}, 32'(count), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int f0;
    reset = 1'b1; clk_in = 1'b1; serial_in = 1'b1;
    repeat (4) @(negedge ref_clk);
    check("rst_receive",    32'(receive),    32'd0);
    check("rst_count",      32'(count),      32'd0);
    check("rst_data_out",   32'(data_out),   32'd0);
    check("rst_overflow",   32'(overflow),   32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    check("rst_frame_err",  32'(frame_err),  32'd0);
    reset = 1'b0;
    @(negedge ref_clk);

    // Single good frame, held then popped by the monitor
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("f1c_receive",  32'(receive),  32'd1);
    check("f1c_count",    32'(count),    32'd1);
    check("f1c_data_out", 32'(data_out), 32'h1C);
    pop_en = 1'b1;
    wait_drain("f1c");
    check("f1c_receive0", 32'(receive), 32'd0);

    // Bad parity: dropped with a parity_err pulse
    p0 = perr_seen;
    send_frame(8'hAA, 1'b0, 1'b1, 1'b0);
    check("par_pulses", 32'(perr_seen - p0), 32'd1);
    check("par_count",  32'(count),          32'd0);
    check("par_receive", 32'(receive),       32'd0);

    // Bad stop bit: frame_err, then line held low for 3 edges before release
    f0 = ferr_seen;
    send_frame(8'hAA, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b0, 1'b0);
    check("stop_pulses", 32'(ferr_seen - f0), 32'd1);
    check("stop_count",  32'(count),          32'd0);
    serial_in = 1'b1;
    repeat (6) @(negedge ref_clk);
    exp_q.push_back(8'h55);
    send_frame(8'h55, odd_par(8'h55), 1'b1, 1'b0);
    wait_drain("f55");

    // Five frames into a 4-deep FIFO with no pops
    pop_en = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      logic [7:0] d;
      d = 8'(i);
      if (i <= 4) exp_q.push_back(d);
      send_frame(d, odd_par(d), 1'b1, 1'b0);
    end
    check("ovf_count",    32'(count),    32'd4);
    check("ovf_flag",     32'(overflow), 32'd1);
    check("ovf_head",     32'(data_out), 32'h01);
    pop_en = 1'b1;
    wait_drain("ovf");
    check("ovf_sticky",   32'(overflow), 32'd1);

    // Full FIFO with a pop on the push cycle: no overflow, count held
    do_reset();
    check("rst2_overflow", 32'(overflow), 32'd0);
    pop_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      logic [7:0] d;
      d = 8'(i);
      exp_q.push_back(d);
      send_frame(d, odd_par(d), 1'b1, 1'b0);
    end
    check("full_count", 32'(count), 32'd4);
    exp_q.push_back(8'h06);
    send_frame(8'h06, odd_par(8'h06), 1'b1, 1'b1);
    check("pp_count",    32'(count),    32'd4);
    check("pp_overflow", 32'(overflow), 32'd0);
    check("pp_head",     32'(data_out), 32'h02);
    pop_en = 1'b1;
    wait_drain("pp");

`ifdef PS2_RX_TIMEOUT_EN
    // Stall after 4 data bits: watchdog aborts, next frame is clean
    f0 = ferr_seen;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
    repeat (801 + HALF) @(negedge ref_clk);
    check("tmo_pulses", 32'(ferr_seen - f0), 32'd1);
    check("tmo_count",  32'(count),          32'd0);
    exp_q.push_back(8'h33);
    send_frame(8'h33, odd_par(8'h33), 1'b1, 1'b0);
    wait_drain("tmo");
`endif

    repeat (4) @(negedge ref_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
